// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) round-robin arbiter in front of a single-ported synchronous memory.
// Each access walks IDLE -> ISSUE -> WAIT -> DONE; all outputs come straight from registers.
module mem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              grant_d
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_r;
    logic              last_d_r;
    logic              grant_d_r;
    logic              op_we_r;
    logic              if_ack_r;
    logic              d_ack_r;
    logic              busy_r;
    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r;
    logic [DATA_W-1:0] if_rdata_r;
    logic [DATA_W-1:0] d_rdata_r;
    logic              win_d_s;

    // Round-robin winner: on contention the port not granted last goes first.
    always_comb begin
        win_d_s = 1'b0;
        if (if_req && d_req) begin
            win_d_s = ~last_d_r;
        end else if (d_req) begin
            win_d_s = 1'b1;
        end else begin
            win_d_s = 1'b0;
        end
    end

    // Access sequencer with registered memory-side and requester-side outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            last_d_r    <= 1'b1;
            grant_d_r   <= 1'b0;
            op_we_r     <= 1'b0;
            if_ack_r    <= 1'b0;
            d_ack_r     <= 1'b0;
            busy_r      <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= {DATA_W{1'b0}};
            if_rdata_r  <= {DATA_W{1'b0}};
            d_rdata_r   <= {DATA_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if_ack_r <= 1'b0;
                    d_ack_r  <= 1'b0;
                    if (if_req || d_req) begin
                        state_r     <= ISSUE;
                        busy_r      <= 1'b1;
                        grant_d_r   <= win_d_s;
                        last_d_r    <= win_d_s;
                        op_we_r     <= win_d_s & d_we;
                        mem_we_r    <= win_d_s & d_we;
                        mem_addr_r  <= win_d_s ? d_addr : if_addr;
                        mem_wdata_r <= win_d_s ? d_wdata : {DATA_W{1'b0}};
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ISSUE: begin
                    mem_we_r <= 1'b0;
                    state_r  <= WAIT;
                end
                WAIT: begin
                    state_r <= DONE;
                    // Memory data is valid now, one cycle after the address was presented.
                    if (grant_d_r) begin
                        d_ack_r <= 1'b1;
                        if (!op_we_r) begin
                            d_rdata_r <= mem_rdata;
                        end
                    end else begin
                        if_ack_r   <= 1'b1;
                        if_rdata_r <= mem_rdata;
                    end
                end
                DONE: begin
                    if_ack_r <= 1'b0;
                    d_ack_r  <= 1'b0;
                    busy_r   <= 1'b0;
                    state_r  <= IDLE;
                end
                default: begin
                    if_ack_r <= 1'b0;
                    d_ack_r  <= 1'b0;
                    busy_r   <= 1'b0;
                    mem_we_r <= 1'b0;
                    state_r  <= IDLE;
                end
            endcase
        end
    end

    assign if_ack    = if_ack_r;
    assign if_rdata  = if_rdata_r;
    assign d_ack     = d_ack_r;
    assign d_rdata   = d_rdata_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign busy      = busy_r;
    assign grant_d   = grant_d_r;

endmodule
